rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8.sv | 125 ++++++++++++
 tb/tb_rr_arbiter8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant hold and an optional hold timeout.
// Grant, index and valid are registered so the shared resource sees a stable owner.
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [0:0]       state, state_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic [IDX_W-1:0] owner, owner_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [N-1:0]     gnt_d;
    logic [IDX_W-1:0] idx_d;
    logic             vld_d;
    logic [IDX_W-1:0] owner_inc;
    logic [N-1:0]     contenders;
    logic [IDX_W-1:0] win;
    logic             load;

    // First set bit of r searching upward from start; index arithmetic wraps since N is 2**IDX_W.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = start + IDX_W'(i);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign owner_inc  = owner + IDX_W'(1);
    assign contenders = req & ~gnt;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        cnt_d   = cnt;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        vld_d   = gnt_valid;
        win     = '0;
        load    = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    win  = pick(req, ptr);
                    load = 1'b1;
                end
            end
            default: begin
                if (!req[owner]) begin
                    ptr_d = owner_inc;
                    if (|req) begin
                        win  = pick(req, owner_inc);
                        load = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (TIMEOUT_EN && cnt == HOLD_LAST && |contenders) begin
                    // Old owner is masked out so it cannot win its own timeout.
                    ptr_d = owner_inc;
                    win   = pick(contenders, owner_inc);
                    load  = 1'b1;
                end else if (cnt != HOLD_LAST) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
        endcase

        if (load) begin
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
            idx_d   = win;
            vld_d   = 1'b1;
            owner_d = win;
            cnt_d   = '0;
            state_d = GRANT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            owner     <= owner_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= vld_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: expected grants queued as requests are driven,
// popped and compared one cycle later when the registered grant appears.
module tb_rr_arbiter8;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int   total  = 0;
    int   passed = 0;
    exp_t exp_q[$];

    rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_HOLD(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // Structural invariants sampled on the falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((gnt & (gnt - 8'd1)) !== 8'h00 || gnt_valid !== (|gnt) ||
                (gnt_valid && gnt !== (8'h01 << gnt_idx))) begin
                $display("FAIL invariant @%0t: gnt=%b idx=%0d vld=%b required one-hot gnt matching idx, vld=|gnt",
                         $time, gnt, gnt_idx, gnt_valid);
            end else begin
                passed++;
            end
        end
    end

    // Queue the expected output, then drive req for the next sampling edge.
    task automatic step(input logic [7:0] r, input exp_t e);
        exp_q.push_back(e);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        req   = 8'hFF;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            $display("FAIL reset_hold: gnt=%h idx=%0d vld=%b required gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_valid);
        end else passed++;

        rst_n = 1'b1;
        step(8'hFF, {8'h01, 3'd0, 1'b1});
        e = exp_q.pop_front();
        total++;
        if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
            $display("FAIL reset_first_grant: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                     gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
        end else passed++;

        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            $display("FAIL reset_async: gnt=%h vld=%b required gnt=00 vld=0 before next edge", gnt, gnt_valid);
        end else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            step(8'h08, {8'h08, 3'd3, 1'b1});
            e = exp_q.pop_front();
            total++;
            if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
                $display("FAIL single[%0d]: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                         k, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
            end else passed++;
        end
        step(8'h00, {8'h00, 3'd3, 1'b0});
        e = exp_q.pop_front();
        total++;
        if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
            $display("FAIL single_drop: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                     gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] rq[3] = '{8'h81, 8'h81, 8'h80};
        exp_t       ex[3] = '{{8'h01, 3'd0, 1'b1}, {8'h01, 3'd0, 1'b1}, {8'h80, 3'd7, 1'b1}};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step(rq[k], ex[k]);
            e = exp_q.pop_front();
            total++;
            if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
                $display("FAIL back_to_back[%0d]: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                         k, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
            end else passed++;
        end
    endtask

    task automatic test_fairness();
        exp_t       e;
        logic [2:0] id;
        apply_reset();
        for (int k = 0; k < 33; k++) begin
            id = 3'((k / 4) % 8);
            step(8'hFF, {8'h01 << id, id, 1'b1});
            e = exp_q.pop_front();
            total++;
            if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
                $display("FAIL fairness[%0d]: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                         k, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
            end else passed++;
        end
    endtask

    task automatic test_pointer_wrap();
        exp_t e;
        logic [7:0] rq[3] = '{8'h80, 8'h42, 8'h40};
        exp_t       ex[3] = '{{8'h80, 3'd7, 1'b1}, {8'h02, 3'd1, 1'b1}, {8'h40, 3'd6, 1'b1}};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step(rq[k], ex[k]);
            e = exp_q.pop_front();
            total++;
            if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
                $display("FAIL pointer_wrap[%0d]: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                         k, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
            end else passed++;
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        logic [7:0] rq[7] = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h20, 8'h20, 8'h00};
        exp_t       ex[7] = '{{8'h04, 3'd2, 1'b1}, {8'h04, 3'd2, 1'b1}, {8'h04, 3'd2, 1'b1},
                              {8'h04, 3'd2, 1'b1}, {8'h20, 3'd5, 1'b1}, {8'h20, 3'd5, 1'b1},
                              {8'h00, 3'd5, 1'b0}};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            step(rq[k], ex[k]);
            e = exp_q.pop_front();
            total++;
            if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v) begin
                $display("FAIL simultaneous[%0d]: gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
                         k, gnt, gnt_idx, gnt_valid, e.g, e.i, e.v);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_pointer_wrap();
        test_simultaneous();
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
